mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: store buffer with youngest-match load forwarding,
// in-order drain to data memory, and single outstanding load-miss handling.
module mem_stage_ctrl #(
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        sb_empty,
  output logic [15:0] dm_addr,
  output logic        dm_re,
  output logic        dm_we,
  output logic [15:0] dm_wrt_data,
  input  logic [15:0] dm_rd_data
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [15:0]   sb_addr_r [SB_DEPTH];
  logic [15:0]   sb_data_r [SB_DEPTH];
  logic [PW-1:0] head_r, tail_r, head_s, tail_s;
  logic [CW-1:0] count_r, count_s, remain_s;

  logic          dm_re_r, dm_we_r, rsp_valid_r;
  logic [15:0]   dm_addr_r, dm_wrt_data_r, rsp_data_r;
  logic          dm_re_s, dm_we_s, rsp_valid_s;
  logic [15:0]   dm_addr_s, dm_wrt_data_s, rsp_data_s;

  logic          accept_s, push_s, load_s, pop_s, hit_s;
  logic [15:0]   hit_data_s;
  logic [PW-1:0] slot_s;

  assign req_ready   = ~rst & (state_r == IDLE) & (~req_we | (count_r < DEPTH_C));
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign dm_re       = dm_re_r;
  assign dm_we       = dm_we_r;
  assign dm_addr     = dm_addr_r;
  assign dm_wrt_data = dm_wrt_data_r;
  assign sb_empty    = (count_r == {CW{1'b0}}) & ~dm_we_r;

  // Forwarding search, oldest to youngest so the youngest match wins; the
  // entry currently being written to DM is still counted as valid.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = 16'h0000;
    slot_s     = head_r;
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot_s     = head_r + PW'(k);
      hit_s      = hit_s | ((CW'(k) < count_r) & (sb_addr_r[slot_s] == req_addr));
      hit_data_s = ((CW'(k) < count_r) & (sb_addr_r[slot_s] == req_addr)) ? sb_data_r[slot_s] : hit_data_s;
    end
  end

  // Next state, buffer bookkeeping and next-cycle DM/response commands.
  always_comb begin
    accept_s      = req_valid & req_ready;
    push_s        = accept_s & req_we;
    load_s        = accept_s & ~req_we;
    pop_s         = dm_we_r;
    remain_s      = count_r - CW'(pop_s);
    count_s       = remain_s + CW'(push_s);
    head_s        = head_r + PW'(pop_s);
    tail_s        = tail_r + PW'(push_s);
    state_s       = state_r;
    dm_re_s       = 1'b0;
    dm_we_s       = 1'b0;
    dm_addr_s     = dm_addr_r;
    dm_wrt_data_s = dm_wrt_data_r;
    rsp_valid_s   = 1'b0;
    rsp_data_s    = rsp_data_r;

    case (state_r)
      IDLE:    state_s = (load_s & ~hit_s) ? LOAD : IDLE;
      LOAD:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    if (load_s & hit_s) begin
      rsp_valid_s = 1'b1;
      rsp_data_s  = hit_data_s;
    end else if (state_r == LOAD) begin
      rsp_valid_s = 1'b1;
      rsp_data_s  = dm_rd_data;
    end else begin
      rsp_valid_s = 1'b0;
      rsp_data_s  = rsp_data_r;
    end

    // A fresh miss wins the DM port; otherwise drain from the post-pop head,
    // which is the incoming store itself when the buffer would be empty.
    if (load_s & ~hit_s) begin
      dm_re_s   = 1'b1;
      dm_addr_s = req_addr;
    end else if (count_s != {CW{1'b0}}) begin
      dm_we_s       = 1'b1;
      dm_addr_s     = (remain_s == {CW{1'b0}}) ? req_addr  : sb_addr_r[head_s];
      dm_wrt_data_s = (remain_s == {CW{1'b0}}) ? req_wdata : sb_data_r[head_s];
    end else begin
      dm_re_s = 1'b0;
      dm_we_s = 1'b0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      head_r        <= {PW{1'b0}};
      tail_r        <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      dm_re_r       <= 1'b0;
      dm_we_r       <= 1'b0;
      dm_addr_r     <= 16'h0000;
      dm_wrt_data_r <= 16'h0000;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 16'h0000;
    end else begin
      state_r       <= state_s;
      head_r        <= head_s;
      tail_r        <= tail_s;
      count_r       <= count_s;
      dm_re_r       <= dm_re_s;
      dm_we_r       <= dm_we_s;
      dm_addr_r     <= dm_addr_s;
      dm_wrt_data_r <= dm_wrt_data_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_data_r    <= rsp_data_s;
    end
  end

  // Store-buffer payload storage; validity is tracked by head/count only.
  always_ff @(posedge clk) begin
    if (push_s) begin
      sb_addr_r[tail_r] <= req_addr;
      sb_data_r[tail_r] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: a program-order shadow memory gives
// expected load data, queued write/response expectations are matched by a monitor.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        sb_empty;
  logic [15:0] dm_addr;
  logic        dm_re;
  logic        dm_we;
  logic [15:0] dm_wrt_data;
  logic [15:0] dm_rd_data = 16'h0000;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [15:0] mem    [0:255];
  logic [15:0] shadow [0:255];
  logic [31:0] wq [$];
  logic [15:0] rq [$];

  mem_stage_ctrl #(.SB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sb_empty(sb_empty),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we),
    .dm_wrt_data(dm_wrt_data), .dm_rd_data(dm_rd_data)
  );

  always #5 clk = ~clk;

  // Data-memory model and scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] wexp;
    logic [15:0] rexp;
    if (mon_en) begin
      checks++;
      if (dm_re && dm_we) begin
        errors++; $display("FAIL dm_exclusive got re=%b we=%b want not both", dm_re, dm_we);
      end
      if (dm_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++; $display("FAIL dm_write got %h<-%h want no write", dm_addr, dm_wrt_data);
        end else begin
          wexp = wq.pop_front();
          if ({dm_addr, dm_wrt_data} !== wexp) begin
            errors++; $display("FAIL dm_write got %h<-%h want %h<-%h", dm_addr, dm_wrt_data, wexp[31:16], wexp[15:0]);
          end
        end
      end
      if (rsp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++; $display("FAIL rsp got %h want no response", rsp_data);
        end else begin
          rexp = rq.pop_front();
          if (rsp_data !== rexp) begin
            errors++; $display("FAIL rsp_data got %h want %h", rsp_data, rexp);
          end
        end
      end
    end
    if (dm_we) mem[dm_addr[7:0]] = dm_wrt_data;
    if (dm_re) dm_rd_data <= mem[dm_addr[7:0]];
  end

  task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    #1;
    while (!req_ready && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got ready=0 want ready=1 addr=%h", addr);
      req_valid = 1'b0;
    end else begin
      if (we) begin
        wq.push_back({addr, data});
        shadow[addr[7:0]] = data;
      end else begin
        rq.push_back(shadow[addr[7:0]]);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
    @(negedge clk);
    checks++;
    if ({dm_re, dm_we, rsp_valid, req_ready, sb_empty} !== 5'b00001) begin
      errors++; $display("FAIL reset_ctrl got %b want 00001", {dm_re, dm_we, rsp_valid, req_ready, sb_empty});
    end
    checks++;
    if ({dm_addr, dm_wrt_data, rsp_data} !== 48'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {dm_addr, dm_wrt_data, rsp_data});
    end
    req_valid = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_drain();
    send(1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    checks++;
    if ({dm_we, dm_re, dm_addr, dm_wrt_data} !== {2'b10, 16'h0010, 16'hBEEF}) begin
      errors++; $display("FAIL drain_write got we=%b re=%b %h<-%h want we=1 re=0 0010<-beef", dm_we, dm_re, dm_addr, dm_wrt_data);
    end
    @(negedge clk);
    checks++;
    if ({dm_we, sb_empty} !== 2'b01) begin
      errors++; $display("FAIL drain_done got we=%b empty=%b want we=0 empty=1", dm_we, sb_empty);
    end
  endtask

  task automatic test_load_miss();
    idle(2);
    send(1'b0, 16'h0020, 16'h0000);
    @(negedge clk);
    checks++;
    if ({dm_re, dm_we, rsp_valid, dm_addr} !== {3'b100, 16'h0020}) begin
      errors++; $display("FAIL miss_cmd got re=%b we=%b rv=%b addr=%h want 1 0 0 0020", dm_re, dm_we, rsp_valid, dm_addr);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, dm_re, rsp_data} !== {2'b10, 16'h1234}) begin
      errors++; $display("FAIL miss_rsp got rv=%b re=%b data=%h want 1 0 1234", rsp_valid, dm_re, rsp_data);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b0, 16'h1234}) begin
      errors++; $display("FAIL rsp_hold got rv=%b data=%h want 0 1234", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_forward();
    idle(2);
    send(1'b1, 16'h0030, 16'h1111);
    send(1'b1, 16'h0030, 16'h2222);
    send(1'b0, 16'h0030, 16'h0000);
    @(negedge clk);
    checks++;
    if ({rsp_valid, dm_re, rsp_data} !== {2'b10, 16'h2222}) begin
      errors++; $display("FAIL fwd_hit got rv=%b re=%b data=%h want 1 0 2222", rsp_valid, dm_re, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (dm_re !== 1'b0) begin
      errors++; $display("FAIL fwd_no_read got re=%b want 0", dm_re);
    end
  endtask

  task automatic test_back_to_back();
    idle(2);
    for (int i = 0; i < 5; i++) send(1'b1, 16'h0050 + 16'(i), 16'h5000 + 16'(i));
    idle(8);
    checks++;
    if (sb_empty !== 1'b1 || wq.size() != 0) begin
      errors++; $display("FAIL b2b_drained got empty=%b pending=%0d want 1 0", sb_empty, wq.size());
    end
  endtask

  task automatic test_miss_vs_drain();
    idle(2);
    send(1'b1, 16'h0041, 16'h4141);
    send(1'b1, 16'h0042, 16'h4242);
    send(1'b0, 16'h0040, 16'h0000);
    @(negedge clk);
    checks++;
    if ({dm_re, dm_we, dm_addr} !== {2'b10, 16'h0040}) begin
      errors++; $display("FAIL miss_prio got re=%b we=%b addr=%h want 1 0 0040", dm_re, dm_we, dm_addr);
    end
    idle(3);
    send(1'b1, 16'h0060, 16'hAAAA);
    idle(3);
    send(1'b0, 16'h0060, 16'h0000);
    @(negedge clk);
    checks++;
    if ({dm_re, dm_addr} !== {1'b1, 16'h0060}) begin
      errors++; $display("FAIL drained_miss got re=%b addr=%h want 1 0060", dm_re, dm_addr);
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    send(1'b1, 16'h0070, 16'h7070);
    send(1'b1, 16'h0071, 16'h7171);
    send(1'b0, 16'h0072, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({dm_re, dm_we, rsp_valid, req_ready, sb_empty} !== 5'b00001) begin
      errors++; $display("FAIL rst_mid_ctrl got %b want 00001", {dm_re, dm_we, rsp_valid, req_ready, sb_empty});
    end
    checks++;
    if ({dm_addr, dm_wrt_data, rsp_data} !== 48'h0) begin
      errors++; $display("FAIL rst_mid_data got %h want 0", {dm_addr, dm_wrt_data, rsp_data});
    end
    @(negedge clk);
    rst = 1'b0;
    rq.delete();
    wq.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({dm_we, rsp_valid} !== 2'b00) begin
        errors++; $display("FAIL rst_mid_quiet got we=%b rv=%b want 0 0", dm_we, rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 16'h0080 + 16'($urandom_range(0, 7)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(10);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'hA000 + 16'(i);
      shadow[i] = mem[i];
    end
    mem[8'h20] = 16'h1234; shadow[8'h20] = 16'h1234;
    mem[8'h40] = 16'h4040; shadow[8'h40] = 16'h4040;
    mem[8'h72] = 16'h7272; shadow[8'h72] = 16'h7272;
    test_reset();
    test_drain();
    test_load_miss();
    test_forward();
    test_back_to_back();
    test_miss_vs_drain();
    test_reset_mid();
    test_random();
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got rsp=%0d wr=%0d want 0 0", rq.size(), wq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
